// File: rtl/acc_accum.sv
// acc_accum: serial accumulator, {co, y} <= y + zero_extend(a) on every rising iclk edge.
module acc_accum #(
  parameter int AW = 1,
  parameter int W  = 1
) (
  input  logic          iclk,
  input  logic          rst,
  input  logic [AW-1:0] a,
  output logic [W-1:0]  y,
  output logic          co
);
  logic [W-1:0] r_y;
  logic         r_co;
  logic [W:0]   w_sum;
  if (W < 1 || AW < 1 || AW > W) begin : g_bad_params
    $error("acc_accum: parameters must satisfy 1 <= AW <= W");
  end
  // widen both operands to W+1 bits so the top bit captures the carry-out
  assign w_sum = {1'b0, r_y} + {{(W + 1 - AW){1'b0}}, a};
  always_ff @(posedge iclk or posedge rst)
    if (rst) {r_co, r_y} <= '0;
    else     {r_co, r_y} <= w_sum;
  assign y  = r_y;
  assign co = r_co;
`ifndef SYNTHESIS
  logic [W-1:0] r_y_snap;
  always_ff @(posedge iclk or posedge rst)
    if (rst) r_y_snap <= '0;
    else     r_y_snap <= w_sum[W-1:0];
  // y may only move at an iclk rise or under reset, never mid-cycle
  always @(negedge iclk)
    if (!rst) assert (y == r_y_snap) else $error("acc_accum: y changed away from iclk rise");
`endif
endmodule

// File: tb/tb_acc_accum.sv
// tb_acc_accum: directed table plus hand sequences over three widths of acc_accum.
module tb_acc_accum;
  logic       iclk, rst;
  logic       a1, a4;
  logic [1:0] a42;
  logic       y1, co1, co4, co42;
  logic [3:0] y4, y42;
  int n_chk = 0, n_pass = 0;

  acc_accum #(.AW(1), .W(1)) d1  (.iclk(iclk), .rst(rst), .a(a1),  .y(y1),  .co(co1));
  acc_accum #(.AW(1), .W(4)) d4  (.iclk(iclk), .rst(rst), .a(a4),  .y(y4),  .co(co4));
  acc_accum #(.AW(2), .W(4)) d42 (.iclk(iclk), .rst(rst), .a(a42), .y(y42), .co(co42));

  typedef struct {
    logic       a1, a4;
    logic [1:0] a42;
    logic       y1, co1;
    logic [3:0] y4;
    logic       co4;
    logic [3:0] y42;
    logic       co42;
  } vec_t;
  vec_t tbl[17];

  task automatic chk(input string name, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
  endtask

  task automatic pulse();
    iclk = 1'b1;
    #5 iclk = 1'b0;
    #5;
  endtask

  task automatic chk_all(input string tag, input int ey1, input int eco1, input int ey4,
                         input int eco4, input int ey42, input int eco42);
    chk({tag, " y1"}, y1, ey1);     chk({tag, " co1"}, co1, eco1);
    chk({tag, " y4"}, y4, ey4);     chk({tag, " co4"}, co4, eco4);
    chk({tag, " y42"}, y42, ey42);  chk({tag, " co42"}, co42, eco42);
  endtask

  initial begin
    //         a1 a4 a42 y1 co1 y4 co4 y42 co42
    tbl[0]  = '{1, 1, 3, 1, 0,  1, 0,  3, 0};
    tbl[1]  = '{1, 1, 3, 0, 1,  2, 0,  6, 0};
    tbl[2]  = '{0, 1, 3, 0, 0,  3, 0,  9, 0};
    tbl[3]  = '{1, 1, 3, 1, 0,  4, 0, 12, 0};
    tbl[4]  = '{0, 1, 3, 1, 0,  5, 0, 15, 0};
    tbl[5]  = '{0, 1, 3, 1, 0,  6, 0,  2, 1};
    tbl[6]  = '{0, 1, 2, 1, 0,  7, 0,  4, 0};
    tbl[7]  = '{0, 1, 1, 1, 0,  8, 0,  5, 0};
    tbl[8]  = '{0, 1, 0, 1, 0,  9, 0,  5, 0};
    tbl[9]  = '{1, 1, 3, 0, 1, 10, 0,  8, 0};
    tbl[10] = '{1, 1, 3, 1, 0, 11, 0, 11, 0};
    tbl[11] = '{1, 1, 3, 0, 1, 12, 0, 14, 0};
    tbl[12] = '{0, 1, 3, 0, 0, 13, 0,  1, 1};
    tbl[13] = '{1, 1, 3, 1, 0, 14, 0,  4, 0};
    tbl[14] = '{0, 1, 1, 1, 0, 15, 0,  5, 0};
    tbl[15] = '{0, 1, 0, 1, 0,  0, 1,  5, 0};
    tbl[16] = '{1, 0, 2, 0, 1,  0, 0,  7, 0};

    iclk = 1'b0; rst = 1'b0; a1 = 1'b0; a4 = 1'b0; a42 = 2'd0;
    #2 rst = 1'b1;
    #1 chk_all("rst immediate", 0, 0, 0, 0, 0, 0);
    #32 chk_all("rst held", 0, 0, 0, 0, 0, 0);
    a1 = 1'b1; a4 = 1'b1; a42 = 2'd3;
    pulse();
    chk_all("rst over edge", 0, 0, 0, 0, 0, 0);
    rst = 1'b0; a1 = 1'b0; a4 = 1'b0; a42 = 2'd0;
    #5 pulse();
    chk_all("first edge after rst", 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 17; i++) begin
      a1 = tbl[i].a1; a4 = tbl[i].a4; a42 = tbl[i].a42;
      pulse();
      chk_all($sformatf("step%0d", i), tbl[i].y1, tbl[i].co1, tbl[i].y4, tbl[i].co4,
              tbl[i].y42, tbl[i].co42);
    end

    a1 = 1'b1; a4 = 1'b0; a42 = 2'd0;
    pulse();
    chk("set y1", y1, 1);
    a1 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      pulse();
      chk_all($sformatf("hold%0d", i), 1, 0, 0, 0, 7, 0);
    end
    #2 a1 = 1'b1; a42 = 2'd3;
    #2 a1 = 1'b0; a42 = 2'd1;
    #2 a1 = 1'b1;
    #1 chk_all("no edge toggles", 1, 0, 0, 0, 7, 0);
    a1 = 1'b0; a42 = 2'd0;

    #3 rst = 1'b1;
    #1 chk_all("async rst mid run", 0, 0, 0, 0, 0, 0);
    #4 rst = 1'b0;
    a1 = 1'b1; a4 = 1'b1; a42 = 2'd3;
    #5 pulse();
    chk_all("after async rst", 1, 0, 1, 0, 3, 0);
    rst = 1'b1; iclk = 1'b1;
    #1 chk_all("rst with edge", 0, 0, 0, 0, 0, 0);
    #4 iclk = 1'b0;
    #5 rst = 1'b0;
    #1 chk_all("rst released", 0, 0, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/acc_accum.md
Name: acc_accum

Overview:
- Serial accumulator clocked by `iclk`; implements the `acc` function of the addac datapath.
- On each rising `iclk` edge it adds input `a` into an internal register and presents the registered sum on `y`.
- With default parameters (1-bit), `y` toggles whenever `a`=1 is sampled, i.e. a running XOR/parity of the samples of `a`.
- Intended as the accumulating stage behind an adder in the addac block.

Parameters:
- AW, 1, width of addend input `a` (1 ≤ AW ≤ W).
- W, 1, width of accumulator / output `y`.

Ports:
- iclk  input   1   clock; all state updates on rising edge.
- rst   input   1   asynchronous reset, active-high.
- a     input   AW  addend, sampled at rising `iclk`.
- y     output  W   accumulated value; registered output.
- co    output  1   carry-out of the most recent accumulation; registered.

Behaviour:
- Reset:
  - `rst`=1 immediately, independent of `iclk`, forces `y`=0 and `co`=0.
  - Both hold while `rst`=1, including across `iclk` edges.
  - Reset deasserted mid-operation: the first `iclk` rising edge after release performs a normal accumulation from 0.
- Accumulate, on each rising `iclk` with `rst`=0:
  - `{co, y} <= y + zero_extend(a)`, computed at W+1 bits.
  - `y` keeps the low W bits; `co` gets bit W.
- Arithmetic:
  - Unsigned, modulo 2^W; wrap-around is silent apart from `co`.
  - For W=1, AW=1: y_next = y XOR a and co_next = y AND a.
- Latency: one `iclk` edge; `y` and `co` change only after the rising edge, never combinationally from `a`.
- `a`=0 at an edge: `y` holds its value and `co` is set to 0.
- No enable input: every rising `iclk` edge is an accumulation.
- Falling `iclk` edges, and glitch-free level changes of `a` between edges, have no effect.
- Before the first reset, `y`/`co` are undefined; the bench must apply reset before checking.
- Simultaneous `rst` assertion and `iclk` edge: reset wins, outputs = 0.
- Synthesizable RTL:
  - Registers with asynchronous-reset flops.
  - Include parameter legality checks (AW ≤ W, W ≥ 1).
  - Include simulation assertions: `y` stable except at `iclk` rise or `rst`.

Test Plan:
- Reset: pulse `rst`=1 for 33 ns with `iclk` idle → `y`=0, `co`=0 immediately and held; release, `a`=0, one `iclk` pulse → `y`=0.
- Toggle sequence (W=1): after reset apply `a`=1,1,0,1 on four `iclk` rising edges → `y`=1,0,0,1 and `co`=0,1,0,0.
- Hold: `y`=1, `a`=0 for 5 edges → `y` stays 1; toggling `a` between edges without an edge → `y` unchanged.
- Async reset mid-run: `y`=1, assert `rst` between edges → `y`=0 without a clock edge; assert `rst` coincident with a rising edge and `a`=1 → `y`=0.
- Wrap (W=4, AW=1): 15 edges with `a`=1 → `y`=15, `co`=0; 16th edge → `y`=0, `co`=1; 17th edge with `a`=0 → `co`=0.
- Multi-bit (W=4, AW=2): `a`=3,3,3,3,3,3 from 0 → `y`=3,6,9,12,15,2 and `co`=1 only on the last edge.
